// File: rtl/booth_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// booth_seq_ctrl_if
//   Handshake/result bundle between the control unit and the sequential Booth
//   multiplier that feeds the HI/LO registers.
//
//   Signals
//     start   request a multiply (control unit -> multiplier)
//     x       multiplier operand, signed       (control unit -> multiplier)
//     y       multiplicand operand, signed     (control unit -> multiplier)
//     busy    multiplier is iterating          (multiplier -> control unit)
//     done    one-cycle result-valid pulse     (multiplier -> control unit)
//     hi_en   HI register write enable         (multiplier -> HI/LO regs)
//     lo_en   LO register write enable         (multiplier -> HI/LO regs)
//     z_high  product bits [2W-1:W]            (multiplier -> HI reg)
//     z_low   product bits [W-1:0]             (multiplier -> LO reg)
//
//   Modports
//     master  control-unit side (drives start/x/y)
//     slave   multiplier side (drives status and product)
// ----------------------------------------------------------------------------
interface booth_seq_ctrl_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             hi_en;
    logic             lo_en;
    logic [WIDTH-1:0] z_high;
    logic [WIDTH-1:0] z_low;

    modport master (
        output start,
        output x,
        output y,
        input  busy,
        input  done,
        input  hi_en,
        input  lo_en,
        input  z_high,
        input  z_low
    );

    modport slave (
        input  start,
        input  x,
        input  y,
        output busy,
        output done,
        output hi_en,
        output lo_en,
        output z_high,
        output z_low
    );

endinterface

// File: rtl/booth_seq_ctrl.sv
// ----------------------------------------------------------------------------
// booth_seq_ctrl
//   Multi-cycle signed WIDTH x WIDTH multiplier using radix-2 Booth recoding,
//   one Booth step per clock. Sits between the control unit and the HI/LO
//   registers in place of a combinational multiplier on the MUL path.
//
//   Ports
//     i_clock  system clock, all state changes on the rising edge
//     i_clear  synchronous active-high reset, overrides every other input
//     bus      booth_seq_ctrl_if.slave
//                start/x/y          request and operands (sampled in IDLE/DONE)
//                busy               high while iterating (RUN)
//                done/hi_en/lo_en   one-cycle pulse in DONE
//                z_high/z_low       registered 2*WIDTH-bit product
//
//   Timing
//     start accepted at edge N -> RUN for WIDTH cycles -> done high in the
//     cycle after edge N+WIDTH. A start seen during DONE re-issues at once,
//     giving one result every WIDTH+1 cycles.
// ----------------------------------------------------------------------------
module booth_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               i_clock,
    input  logic               i_clear,
    booth_seq_ctrl_if.slave    bus
);

    // Wide enough to hold the step index 0..WIDTH.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    // One extra bit so that ACC - M cannot overflow when M = -2^(WIDTH-1).
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_z_high;
    logic [WIDTH-1:0] r_z_low;

    // ------------------------------------------------------------------------
    // Booth step datapath
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_acc_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_qm1_next;
    logic             w_last_step;
    logic             w_accept;

    always_comb begin
        w_m_ext = {r_m[WIDTH-1], r_m};

        unique case ({r_q[0], r_qm1})
            2'b10:   w_sum = r_acc - w_m_ext;
            2'b01:   w_sum = r_acc + w_m_ext;
            default: w_sum = r_acc;
        endcase

        // Arithmetic shift right of {ACC, Q, q_m1}: ACC sign replicated,
        // ACC lsb drops into Q msb, Q lsb becomes the new q_m1.
        w_acc_next  = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_next    = {w_sum[0], r_q[WIDTH-1:1]};
        w_qm1_next  = r_q[0];

        w_last_step = (r_count == CW'(WIDTH - 1));
        w_accept    = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    end

    // ------------------------------------------------------------------------
    // Sequencer and registered result
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_m      <= '0;
            r_z_high <= '0;
            r_z_low  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_q     <= bus.x;
                        r_m     <= bus.y;
                        r_acc   <= '0;
                        r_qm1   <= 1'b0;
                        r_count <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_q     <= w_q_next;
                    r_qm1   <= w_qm1_next;
                    r_count <= r_count + CW'(1);
                    if (w_last_step) begin
                        // Result becomes visible only here; partial products
                        // in ACC/Q never reach the outputs.
                        r_z_high <= w_acc_next[WIDTH-1:0];
                        r_z_low  <= w_q_next;
                        r_state  <= ST_DONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.busy   = (r_state == ST_RUN);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.hi_en  = (r_state == ST_DONE);
    assign bus.lo_en  = (r_state == ST_DONE);
    assign bus.z_high = r_z_high;
    assign bus.z_low  = r_z_low;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_booth_seq_ctrl
//   Self-checking bench for booth_seq_ctrl (WIDTH = 32). Expected products are
//   table constants or a plain signed-multiply model; they are queued when a
//   start is driven and popped when done is observed.
// ----------------------------------------------------------------------------
module tb_booth_seq_ctrl;

    localparam int W       = 32;
    localparam int LAT     = W;    // edges from accepting edge to done visible
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    booth_seq_ctrl_if #(.WIDTH(W)) bus ();

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .i_clock (clk),
        .i_clear (clear),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] sb_q[$];
    logic [2*W-1:0] last_z;

    typedef struct {
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] exp;
        string          name;
    } vec_t;

    vec_t vecs[8];

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [2*W-1:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] exp);
        bus.start = 1'b1;
        bus.x     = a;
        bus.y     = b;
        sb_q.push_back(exp);
    endtask

    // Waits for done after an accepting edge; checks latency, busy span,
    // output hold during RUN and the write enables.
    task automatic wait_done(input string tag);
        int lat;
        int bcnt;
        int hold_bad;
        lat      = 0;
        bcnt     = 0;
        hold_bad = 0;
        while (bus.done !== 1'b1 && lat < TIMEOUT) begin
            if (bus.busy === 1'b1) bcnt++;
            if ({bus.z_high, bus.z_low} !== last_z) hold_bad++;
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " busy_cycles"}, 64'(bcnt), 64'(LAT));
        check({tag, " z_hold_in_run"}, 64'(hold_bad), 64'd0);
        check({tag, " hi_lo_en"}, {62'd0, bus.hi_en, bus.lo_en}, 64'd3);
    endtask

    task automatic pop_check(input string tag);
        logic [2*W-1:0] exp;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_nonempty"}, 64'd0, 64'd1);
        end else begin
            exp = sb_q.pop_front();
            check({tag, " product"}, {bus.z_high, bus.z_low}, exp);
            last_z = exp;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string tag);
        drive_start(a, b, exp);
        step();
        bus.start = 1'b0;
        bus.x     = $urandom;   // operand changes during RUN must be ignored
        bus.y     = $urandom;
        wait_done(tag);
        pop_check(tag);
        step();
        check({tag, " done_pulse_end"}, {62'd0, bus.done, bus.busy}, 64'd0);
        check({tag, " z_hold_idle"}, {bus.z_high, bus.z_low}, last_z);
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        vecs[0] = '{x: 32'd6,          y: 32'd7,          exp: 64'h00000000_0000002A, name: "6x7"};
        vecs[1] = '{x: 32'hFFFFFFFB,   y: 32'd3,          exp: 64'hFFFFFFFF_FFFFFFF1, name: "m5x3"};
        vecs[2] = '{x: 32'h80000000,   y: 32'h80000000,   exp: 64'h40000000_00000000, name: "minxmin"};
        vecs[3] = '{x: 32'h7FFFFFFF,   y: 32'h80000000,   exp: 64'hC0000000_80000000, name: "maxxmin"};
        vecs[4] = '{x: 32'h7FFFFFFF,   y: 32'h7FFFFFFF,   exp: 64'h3FFFFFFF_00000001, name: "maxxmax"};
        vecs[5] = '{x: 32'hFFFFFFFF,   y: 32'd1,          exp: 64'hFFFFFFFF_FFFFFFFF, name: "m1x1"};
        vecs[6] = '{x: 32'd0,          y: 32'h12345678,   exp: 64'h00000000_00000000, name: "0xk"};
        vecs[7] = '{x: 32'd12345,      y: 32'hFFFFFD5A,   exp: 64'hFFFFFFFF_FF80490A, name: "12345xm678"};

        clear     = 1'b1;
        bus.start = 1'b1;   // dropped: clear has priority
        bus.x     = 32'd5;
        bus.y     = 32'd5;
        last_z    = '0;
        step();
        step();
        clear     = 1'b0;
        bus.start = 1'b0;

        check("reset busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("reset hi_lo_en", {62'd0, bus.hi_en, bus.lo_en}, 64'd0);
        check("reset z", {bus.z_high, bus.z_low}, 64'd0);

        // Table-driven products.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].exp, vecs[i].name);
        end

        // Random operands against the signed-multiply model.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = $urandom;
            run_op(a, b, mul_model(a, b), $sformatf("rand%0d", i));
        end

        // start pulse mid-RUN with new operands is ignored.
        begin
            int bcnt;
            bcnt = 0;
            drive_start(32'd2, 32'd3, 64'd6);
            step();
            bus.start = 1'b0;
            for (int j = 0; j < LAT; j++) begin
                if (bus.busy === 1'b1) bcnt++;
                if (j == 9) begin
                    bus.start = 1'b1;
                    bus.x     = 32'd9;
                    bus.y     = 32'd9;
                end else begin
                    bus.start = 1'b0;
                end
                step();
            end
            check("ignore busy_cycles", 64'(bcnt), 64'(LAT));
            check("ignore done", {63'd0, bus.done}, 64'd1);
            pop_check("ignore");
            step();
            check("ignore no_reissue", {62'd0, bus.busy, bus.done}, 64'd0);
        end

        // clear mid-RUN aborts with no done pulse and zeroed outputs.
        begin
            int dcnt;
            dcnt      = 0;
            bus.start = 1'b1;
            bus.x     = 32'd7;
            bus.y     = 32'd5;
            step();
            bus.start = 1'b0;
            repeat (14) step();
            check("abort busy_before", {63'd0, bus.busy}, 64'd1);
            clear = 1'b1;
            step();
            clear = 1'b0;
            check("abort busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
            check("abort z", {bus.z_high, bus.z_low}, 64'd0);
            last_z = '0;
            for (int j = 0; j < 40; j++) begin
                if (bus.done === 1'b1) dcnt++;
                step();
            end
            check("abort no_done", 64'(dcnt), 64'd0);
            run_op(32'd4, 32'd4, 64'd16, "after_abort");
        end

        // start and clear together: start dropped.
        clear     = 1'b1;
        bus.start = 1'b1;
        bus.x     = 32'd3;
        bus.y     = 32'd3;
        step();
        clear     = 1'b0;
        bus.start = 1'b0;
        step();
        check("clear_wins busy", {62'd0, bus.busy, bus.done}, 64'd0);
        last_z = '0;

        // start held high through DONE: back-to-back re-issue.
        drive_start(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);
        step();
        wait_done("b2b_first");
        pop_check("b2b_first");
        sb_q.push_back(64'd1);   // accepted at the DONE-cycle edge
        step();
        bus.start = 1'b0;
        check("b2b reissue", {62'd0, bus.busy, bus.done}, 64'd2);
        wait_done("b2b_second");
        pop_check("b2b_second");
        step();
        check("b2b idle", {62'd0, bus.busy, bus.done}, 64'd0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
